// File: rtl/pcap_dma_pkg.sv
// Shared definitions for the PCAP DMA block controller: status codes, FSM states, word size.
package pcap_dma_pkg;

   localparam int WORD_BYTES = 4;

   localparam logic [3:0] ST_NONE           = 4'd0;
   localparam logic [3:0] ST_BLOCK_FINISHED = 4'd1;
   localparam logic [3:0] ST_CAPT_FINISHED  = 4'd2;
   localparam logic [3:0] ST_TIMEOUT        = 4'd3;
   localparam logic [3:0] ST_DISARM         = 4'd4;
   localparam logic [3:0] ST_ADDR_ERROR     = 4'd5;
   localparam logic [3:0] ST_INT_DISARM     = 4'd6;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_FLUSH  = 2'd2
   } state_t;

endpackage

// File: rtl/pcap_dma_addr_queue.sv
// Two-entry DMA address queue (cur/next). A push into a full queue overwrites next;
// pop promotes next to cur; clear_next drops a stale next entry while keeping cur.
module pcap_dma_addr_queue #(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic          pop,
   input  logic          clear_next,
   output logic [AW-1:0] cur_addr,
   output logic [AW-1:0] next_addr,
   output logic          cur_valid,
   output logic          next_valid
);

   logic [AW-1:0] cur_nxt, next_nxt;
   logic          cur_valid_nxt, next_valid_nxt;

   // Pop first, then drop stale next, then push into whichever slot is free.
   always_comb begin
      cur_nxt        = cur_addr;
      next_nxt       = next_addr;
      cur_valid_nxt  = cur_valid;
      next_valid_nxt = next_valid;
      if (pop) begin
         cur_nxt        = next_addr;
         cur_valid_nxt  = next_valid;
         next_valid_nxt = 1'b0;
      end
      if (clear_next) begin
         next_valid_nxt = 1'b0;
      end
      if (push) begin
         if (!cur_valid_nxt) begin
            cur_nxt       = push_addr;
            cur_valid_nxt = 1'b1;
         end else begin
            next_nxt       = push_addr;
            next_valid_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr   <= '0;
         next_addr  <= '0;
         cur_valid  <= 1'b0;
         next_valid <= 1'b0;
      end else begin
         cur_addr   <= cur_nxt;
         next_addr  <= next_nxt;
         cur_valid  <= cur_valid_nxt;
         next_valid <= next_valid_nxt;
      end
   end

endmodule

// File: rtl/pcap_dma_block_ctrl.sv
// Device-side PCAP DMA responder: buffers samples into host-addressed blocks and reports IRQ status.
// Optional idle-timeout block close is built only when PCAP_DMA_TIMEOUT_EN is defined.
module pcap_dma_block_ctrl
   import pcap_dma_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int TW = 32
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          arm_i,
   input  logic          disarm_i,
   input  logic          enable_i,
   input  logic          overflow_i,
   input  logic [AW-1:0] dmaaddr_i,
   input  logic          dmaaddr_wstb_i,
   input  logic [AW-1:0] block_size_i,
   input  logic [TW-1:0] timeout_i,
   input  logic          irq_status_rstb_i,
   input  logic [DW-1:0] smpl_i,
   input  logic          smpl_valid_i,
   output logic          smpl_ready_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [DW-1:0] wr_data_o,
   output logic          wr_valid_o,
   input  logic          wr_ready_i,
   input  logic          wr_idle_i,
   output logic          irq_o,
   output logic [3:0]    irq_status_o,
   output logic [31:0]   smpl_count_o,
   output logic          active_o
);

   state_t        state, state_nxt;
   logic [AW-1:0] byte_cnt, byte_cnt_inc;
   logic [AW-1:0] q_cur, q_next;
   logic          q_cur_valid, q_next_valid;
   logic          q_pop, q_clear_next;
   logic          enable_d, enable_fall;
   logic          accept, blk_end, tmo_hit, cnt_clr;
   logic          set_irq;
   logic [3:0]    irq_code, pend_code, pend_code_nxt;
   logic [31:0]   irq_cnt;

   pcap_dma_addr_queue #(.AW(AW)) u_addr_queue (
      .clk        (clk_i),
      .rst_n      (reset_n_i),
      .push       (dmaaddr_wstb_i),
      .push_addr  (dmaaddr_i),
      .pop        (q_pop),
      .clear_next (q_clear_next),
      .cur_addr   (q_cur),
      .next_addr  (q_next),
      .cur_valid  (q_cur_valid),
      .next_valid (q_next_valid)
   );

   assign active_o     = (state == S_ACTIVE);
   assign smpl_ready_o = active_o & wr_ready_i & ~irq_o;
   assign accept       = smpl_valid_i & smpl_ready_o;
   assign byte_cnt_inc = byte_cnt + (accept ? AW'(WORD_BYTES) : '0);
   assign blk_end      = accept & (byte_cnt_inc >= block_size_i);
   assign enable_fall  = enable_d & ~enable_i;

`ifdef PCAP_DMA_TIMEOUT_EN
   logic [TW-1:0] idle_cnt;

   assign tmo_hit = active_o && (timeout_i != '0) && (byte_cnt != '0) && !accept && !irq_o
                    && ((idle_cnt + TW'(1)) == timeout_i);

   // Idle time only accumulates while ingest is actually possible.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         idle_cnt <= '0;
      end else if (active_o && !accept && !irq_o && !tmo_hit) begin
         idle_cnt <= idle_cnt + TW'(1);
      end else begin
         idle_cnt <= '0;
      end
   end
`else
   logic tmo_unused;
   assign tmo_unused = ^timeout_i;
   assign tmo_hit    = 1'b0;
`endif

   // Event arbitration: a block end without a follow-on address outranks every stop request.
   always_comb begin
      state_nxt     = state;
      q_pop         = 1'b0;
      q_clear_next  = 1'b0;
      cnt_clr       = 1'b0;
      set_irq       = 1'b0;
      irq_code      = ST_NONE;
      irq_cnt       = 32'(byte_cnt_inc >> 2);
      pend_code_nxt = pend_code;
      case (state)
         S_IDLE: begin
            if (arm_i) begin
               if (q_cur_valid) begin
                  state_nxt    = S_ACTIVE;
                  q_clear_next = 1'b1;
                  cnt_clr      = 1'b1;
               end else begin
                  set_irq  = 1'b1;
                  irq_code = ST_ADDR_ERROR;
                  irq_cnt  = '0;
               end
            end
         end
         S_ACTIVE: begin
            if ((blk_end || tmo_hit) && !q_next_valid) begin
               state_nxt     = S_FLUSH;
               pend_code_nxt = ST_ADDR_ERROR;
            end else if (overflow_i) begin
               state_nxt     = S_FLUSH;
               pend_code_nxt = ST_INT_DISARM;
            end else if (disarm_i) begin
               state_nxt     = S_FLUSH;
               pend_code_nxt = ST_DISARM;
            end else if (enable_fall) begin
               state_nxt     = S_FLUSH;
               pend_code_nxt = ST_CAPT_FINISHED;
            end else if (tmo_hit) begin
               set_irq  = 1'b1;
               irq_code = ST_TIMEOUT;
               q_pop    = 1'b1;
               cnt_clr  = 1'b1;
            end else if (blk_end) begin
               set_irq  = 1'b1;
               irq_code = ST_BLOCK_FINISHED;
               q_pop    = 1'b1;
               cnt_clr  = 1'b1;
            end
         end
         S_FLUSH: begin
            if (wr_idle_i && !wr_valid_o) begin
               set_irq   = 1'b1;
               irq_code  = pend_code;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state     <= S_IDLE;
         pend_code <= ST_NONE;
         byte_cnt  <= '0;
         enable_d  <= 1'b0;
      end else begin
         state     <= state_nxt;
         pend_code <= pend_code_nxt;
         byte_cnt  <= cnt_clr ? '0 : byte_cnt_inc;
         enable_d  <= enable_i;
      end
   end

   // Single-entry output stage; ingest needs wr_ready_i, so a held word drains as the next loads.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_valid_o <= 1'b0;
         wr_addr_o  <= '0;
         wr_data_o  <= '0;
      end else if (accept) begin
         wr_valid_o <= 1'b1;
         wr_addr_o  <= q_cur + byte_cnt;
         wr_data_o  <= smpl_i;
      end else if (wr_ready_i) begin
         wr_valid_o <= 1'b0;
      end
   end

   // A new interrupt wins over a same-cycle acknowledge.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         irq_o        <= 1'b0;
         irq_status_o <= ST_NONE;
         smpl_count_o <= '0;
      end else if (set_irq) begin
         irq_o        <= 1'b1;
         irq_status_o <= irq_code;
         smpl_count_o <= irq_cnt;
      end else if (irq_status_rstb_i) begin
         irq_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pcap_dma_block_ctrl.sv
// Directed and randomized bench for pcap_dma_block_ctrl with a queue-based reference model.
module tb_pcap_dma_block_ctrl;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        arm_i = 1'b0, disarm_i = 1'b0, enable_i = 1'b1, overflow_i = 1'b0;
   logic [31:0] dmaaddr_i = '0;
   logic        dmaaddr_wstb_i = 1'b0;
   logic [31:0] block_size_i = 32'h100;
   logic [31:0] timeout_i = '0;
   logic        irq_status_rstb_i = 1'b0;
   logic [31:0] smpl_i = '0;
   logic        smpl_valid_i = 1'b0;
   logic        smpl_ready_o;
   logic [31:0] wr_addr_o, wr_data_o;
   logic        wr_valid_o;
   logic        wr_ready_i = 1'b0;
   logic        wr_idle_i;
   logic        irq_o;
   logic [3:0]  irq_status_o;
   logic [31:0] smpl_count_o;
   logic        active_o;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] addrq[$];
   logic [31:0] exp_addr[$], exp_data[$], got_addr[$], got_data[$];
   logic [31:0] cur_base;
   int          bytes;

   always #5 clk_i = ~clk_i;

   pcap_dma_block_ctrl dut (
      .clk_i             (clk_i),
      .reset_n_i         (reset_n_i),
      .arm_i             (arm_i),
      .disarm_i          (disarm_i),
      .enable_i          (enable_i),
      .overflow_i        (overflow_i),
      .dmaaddr_i         (dmaaddr_i),
      .dmaaddr_wstb_i    (dmaaddr_wstb_i),
      .block_size_i      (block_size_i),
      .timeout_i         (timeout_i),
      .irq_status_rstb_i (irq_status_rstb_i),
      .smpl_i            (smpl_i),
      .smpl_valid_i      (smpl_valid_i),
      .smpl_ready_o      (smpl_ready_o),
      .wr_addr_o         (wr_addr_o),
      .wr_data_o         (wr_data_o),
      .wr_valid_o        (wr_valid_o),
      .wr_ready_i        (wr_ready_i),
      .wr_idle_i         (wr_idle_i),
      .irq_o             (irq_o),
      .irq_status_o      (irq_status_o),
      .smpl_count_o      (smpl_count_o),
      .active_o          (active_o)
   );

   // Burst-writer stand-in: random backpressure, idle once nothing is held.
   assign wr_idle_i = ~wr_valid_o;

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         wr_ready_i = ($urandom_range(0, 3) != 0);
      end
   end

   always @(negedge clk_i) begin
      if (reset_n_i && wr_valid_o && wr_ready_i) begin
         got_addr.push_back(wr_addr_o);
         got_data.push_back(wr_data_o);
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_model();
      addrq.delete();
      exp_addr.delete();
      exp_data.delete();
      got_addr.delete();
      got_data.delete();
      bytes = 0;
      cur_base = '0;
   endtask

   task automatic apply_reset();
      reset_n_i = 1'b0;
      #1;
      check_output("rst_irq", {31'd0, irq_o}, 32'd0);
      check_output("rst_status", {28'd0, irq_status_o}, 32'd0);
      check_output("rst_count", smpl_count_o, 32'd0);
      check_output("rst_active", {31'd0, active_o}, 32'd0);
      check_output("rst_wr_valid", {31'd0, wr_valid_o}, 32'd0);
      tick();
      reset_n_i = 1'b1;
      clear_model();
      tick();
   endtask

   task automatic model_write(input logic [31:0] addr);
      dmaaddr_i = addr;
      dmaaddr_wstb_i = 1'b1;
      tick();
      dmaaddr_wstb_i = 1'b0;
      if (addrq.size() < 2) addrq.push_back(addr);
      else addrq[1] = addr;
   endtask

   task automatic apply_arm(output logic exp_err);
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
      if (addrq.size() == 0) begin
         exp_err = 1'b1;
      end else begin
         exp_err = 1'b0;
         while (addrq.size() > 1) void'(addrq.pop_back());
         cur_base = addrq[0];
         bytes = 0;
      end
      check_output("arm_active", {31'd0, active_o}, {31'd0, ~exp_err});
   endtask

   task automatic send_words(input int n);
      int sent = 0;
      int guard = 0;
      logic acc;
      smpl_i = $urandom;
      smpl_valid_i = 1'b1;
      while (sent < n && guard < 2000) begin
         @(negedge clk_i);
         acc = smpl_ready_o;
         @(posedge clk_i);
         if (acc) begin
            exp_addr.push_back(cur_base + 32'(bytes));
            exp_data.push_back(smpl_i);
            bytes += 4;
            sent++;
         end
         #1;
         if (acc) smpl_i = $urandom;
         guard++;
      end
      smpl_valid_i = 1'b0;
      check_output("send_accepted", sent, n);
   endtask

   // Block-end rule: switch to next address if queued, else address error.
   task automatic model_block_end(output logic [3:0] code, output logic [31:0] cnt);
      code = 4'd0;
      cnt = 32'(bytes / 4);
      if (bytes >= int'(block_size_i)) begin
         if (addrq.size() > 1) begin
            code = 4'd1;
            void'(addrq.pop_front());
            cur_base = addrq[0];
            bytes = 0;
         end else begin
            code = 4'd5;
         end
      end
   endtask

   task automatic wait_irq(input int bound, output int cycles);
      cycles = 0;
      while (!irq_o && cycles < bound) begin
         tick();
         cycles++;
      end
      check_output("irq_wait", {31'd0, irq_o}, 32'd1);
   endtask

   task automatic apply_ack();
      check_output("ack_irq_before", {31'd0, irq_o}, 32'd1);
      irq_status_rstb_i = 1'b1;
      tick();
      irq_status_rstb_i = 1'b0;
      check_output("ack_irq_after", {31'd0, irq_o}, 32'd0);
   endtask

   task automatic drain_and_compare();
      int g = 0;
      int n;
      while (wr_valid_o && g < 200) begin
         tick();
         g++;
      end
      check_output("wr_drain", {31'd0, wr_valid_o}, 32'd0);
      check_output("wr_count", got_addr.size(), exp_addr.size());
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         check_output("wr_addr", got_addr[i], exp_addr[i]);
         check_output("wr_data", got_data[i], exp_data[i]);
      end
      exp_addr.delete();
      exp_data.delete();
      got_addr.delete();
      got_data.delete();
   endtask

   task automatic check_irq(input logic [3:0] code, input logic [31:0] cnt);
      check_output("irq_level", {31'd0, irq_o}, 32'd1);
      check_output("irq_status", {28'd0, irq_status_o}, {28'd0, code});
      check_output("smpl_count", smpl_count_o, cnt);
   endtask

   initial begin
      logic        err;
      logic [3:0]  code;
      logic [31:0] cnt;
      logic [31:0] base;
      int          cyc;
      int          blk_words;

      clear_model();
      apply_reset();

      // Arm with nothing queued
      apply_arm(err);
      check_irq(4'd5, 32'd0);
      apply_ack();

      // Full block with follow-on address
      apply_reset();
      block_size_i = 32'h100;
      model_write(32'h1000_0000);
      apply_arm(err);
      model_write(32'h1000_0100);
      send_words(64);
      model_block_end(code, cnt);
      check_irq(code, cnt);
      check_output("blk1_active", {31'd0, active_o}, 32'd1);
      drain_and_compare();
      apply_ack();
      disarm_i = 1'b1;
      tick();
      disarm_i = 1'b0;
      wait_irq(50, cyc);
      check_irq(4'd4, 32'd0);
      apply_ack();

      // Full block without follow-on address
      apply_reset();
      model_write(32'h2000_0000);
      apply_arm(err);
      send_words(64);
      model_block_end(code, cnt);
      wait_irq(200, cyc);
      check_irq(code, cnt);
      check_output("noaddr_active", {31'd0, active_o}, 32'd0);
      drain_and_compare();
      apply_ack();

      // Capture finished mid-block; queued next address stays unused
      apply_reset();
      model_write(32'h3000_0000);
      apply_arm(err);
      model_write(32'h3000_0100);
      send_words(10);
      enable_i = 1'b0;
      tick();
      wait_irq(200, cyc);
      check_irq(4'd2, 32'd10);
      check_output("capt_active", {31'd0, active_o}, 32'd0);
      drain_and_compare();
      apply_ack();
      enable_i = 1'b1;
      tick();
      apply_arm(err);
      send_words(2);
      disarm_i = 1'b1;
      tick();
      disarm_i = 1'b0;
      wait_irq(200, cyc);
      check_irq(4'd4, 32'd2);
      drain_and_compare();
      apply_ack();

      // Disarm and overflow together: internal disarm wins
      apply_reset();
      model_write(32'h4000_0000);
      apply_arm(err);
      send_words(3);
      disarm_i = 1'b1;
      overflow_i = 1'b1;
      tick();
      disarm_i = 1'b0;
      overflow_i = 1'b0;
      wait_irq(200, cyc);
      check_irq(4'd6, 32'd3);
      tick();
      tick();
      check_output("irq_held", {31'd0, irq_o}, 32'd1);
      drain_and_compare();
      apply_ack();

      // Randomized block chain
      apply_reset();
      blk_words = $urandom_range(2, 6);
      block_size_i = 32'(blk_words * 4);
      base = $urandom & 32'hFFFF_FFFC;
      model_write(base);
      apply_arm(err);
      model_write(($urandom & 32'hFFFF_FFFC));
      for (int b = 0; b < 3; b++) begin
         send_words(blk_words);
         model_block_end(code, cnt);
         check_irq(code, cnt);
         model_write(($urandom & 32'hFFFF_FFFC));
         apply_ack();
      end
      disarm_i = 1'b1;
      tick();
      disarm_i = 1'b0;
      wait_irq(200, cyc);
      check_irq(4'd4, 32'd0);
      drain_and_compare();
      apply_ack();

      // Idle timeout
      apply_reset();
      block_size_i = 32'h100;
      timeout_i = 32'd100;
      model_write(32'h5000_0000);
      apply_arm(err);
      model_write(32'h5000_0100);
      send_words(5);
`ifdef PCAP_DMA_TIMEOUT_EN
      wait_irq(150, cyc);
      check_output("tmo_cycles", cyc, 100);
      check_irq(4'd3, 32'd5);
      check_output("tmo_active", {31'd0, active_o}, 32'd1);
      apply_ack();
`else
      repeat (150) tick();
      check_output("tmo_no_irq", {31'd0, irq_o}, 32'd0);
      check_output("tmo_active", {31'd0, active_o}, 32'd1);
`endif
      drain_and_compare();
      timeout_i = '0;

      // Reset in the middle of a block
      apply_reset();
      model_write(32'h6000_0000);
      apply_arm(err);
      send_words(5);
      #2;
      reset_n_i = 1'b0;
      #1;
      check_output("midrst_irq", {31'd0, irq_o}, 32'd0);
      check_output("midrst_active", {31'd0, active_o}, 32'd0);
      check_output("midrst_wr_valid", {31'd0, wr_valid_o}, 32'd0);
      tick();
      reset_n_i = 1'b1;
      clear_model();
      tick();
      apply_arm(err);
      check_irq(4'd5, 32'd0);
      apply_ack();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
